conv_sched: RTL

//  Sequencer for the binary 3x3 conv engine. For each output kernel of a layer it:
//  - streams the 9 weight bits from a synchronous weight ROM into the engine;
//  - starts the engine and the sliding-window generator together;
//  - waits for the engine's done pulse, then moves to the next kernel.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_wload.sv | 60 ++++++
 rtl/conv_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv-engine scheduler and weight streamer.
package conv_pkg;

   // Top-level sequencing states for one layer.
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GAP,
      RUN,
      NEXT,
      FIN
   } state_t;

   // Weight taps per 3x3 kernel.
   localparam int KTAPS    = 9;

   // Weight streaming window: one lead cycle plus one cycle per tap.
   localparam int LOAD_CYC = 10;

   // Layer-select encoding driven onto the engine's state input.
   localparam logic L1 = 1'b0;
   localparam logic L2 = 1'b1;

endpackage

// File: rtl/conv_wload.sv
// Streams one kernel's 9 weight bits from the synchronous weight ROM to the engine.
// A start pulse opens a 10-cycle window. Reads are issued on the first nine cycles.
// ROM data lands one cycle later, so bit i appears on the serial output at window cycle i+1.
module conv_wload
   import conv_pkg::*;
#(
   parameter int WA_W = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [WA_W-1:0] base,
   input  logic            wrom_q,
   output logic            wrom_rd,
   output logic [WA_W-1:0] wrom_addr,
   output logic            weight_en,
   output logic            weight,
   output logic            done
);

   localparam int TW = $clog2(LOAD_CYC);

   logic          active;
   logic [TW-1:0] t;

   // Window counter: t runs 0..LOAD_CYC-1 while active, then the window closes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         active <= 1'b0;
         t      <= '0;
      end else if (start) begin
         active <= 1'b1;
         t      <= '0;
      end else if (active) begin
         if (t == TW'(LOAD_CYC - 1)) begin
            active <= 1'b0;
            t      <= '0;
         end else begin
            t <= t + 1'b1;
         end
      end
   end

   // Outputs are decoded from the window position and forced to 0 outside the window.
   always_comb begin
      wrom_rd   = 1'b0;
      wrom_addr = '0;
      weight_en = 1'b0;
      weight    = 1'b0;
      done      = 1'b0;
      if (active) begin
         weight_en = 1'b1;
         wrom_rd   = (t < TW'(KTAPS));
         wrom_addr = base + WA_W'(t);
         weight    = (t != '0) ? wrom_q : 1'b0;
         done      = (t == TW'(LOAD_CYC - 1));
      end
   end

endmodule

// File: rtl/conv_sched.sv
// Per-layer sequencer for the binary 3x3 conv engine and its sliding-window generator.
// For each kernel it loads the weights, waits a short gap, then runs the engine until done.
module conv_sched
   import conv_pkg::*;
#(
   parameter int NK_MAX  = 16,
   parameter int WA_W    = 8,
   parameter int GAP_CYC = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            go,
   input  logic            layer_sel,
   input  logic [4:0]      num_k,
   input  logic [WA_W-1:0] wbase,
   output logic [WA_W-1:0] wrom_addr,
   output logic            wrom_rd,
   input  logic            wrom_q,
   output logic            cv_weight_en,
   output logic            cv_weight,
   output logic            cv_start,
   output logic            cv_state,
   output logic            win_start,
   input  logic            cv_done,
   output logic [4:0]      k_idx,
   output logic            busy,
   output logic            layer_done
);

   localparam int KW = $clog2(NK_MAX);
   localparam int GW = $clog2(GAP_CYC + 1);

   state_t          state;
   state_t          state_nxt;
   logic            sel_q;
   logic [4:0]      nk_q;
   logic [WA_W-1:0] wbase_q;
   logic [KW-1:0]   k_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [4:0]      nk_eff;
   logic [WA_W-1:0] kbase;
   logic            load_start;
   logic            load_done;
   logic            last_k;

   // A zero kernel count runs one kernel; oversize counts are clipped to what the counter holds.
   assign nk_eff = (num_k == 5'd0)           ? 5'd1 :
                   (num_k > 5'(NK_MAX))      ? 5'(NK_MAX) : num_k;

   // ROM base of the current kernel; wraps modulo the address width by construction.
   assign kbase  = wbase_q + WA_W'(KTAPS) * WA_W'(k_cnt);

   assign last_k = (5'(k_cnt) == nk_q - 5'd1);

   conv_wload #(
      .WA_W (WA_W)
   ) u_wload (
      .clk       (clk),
      .rstn      (rstn),
      .start     (load_start),
      .base      (kbase),
      .wrom_q    (wrom_q),
      .wrom_rd   (wrom_rd),
      .wrom_addr (wrom_addr),
      .weight_en (cv_weight_en),
      .weight    (cv_weight),
      .done      (load_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the state-decoded engine/handshake outputs.
   always_comb begin
      state_nxt  = state;
      load_start = 1'b0;
      cv_start   = 1'b0;
      win_start  = 1'b0;
      busy       = 1'b0;
      layer_done = 1'b0;
      cv_state   = 1'b0;
      k_idx      = 5'(k_cnt);
      case (state)
         IDLE: begin
            if (go) begin
               state_nxt  = LOAD;
               load_start = 1'b1;
            end
         end
         LOAD: begin
            busy = 1'b1;
            if (load_done) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            busy = 1'b1;
            if (gap_cnt == GW'(GAP_CYC - 1)) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy      = 1'b1;
            cv_start  = 1'b1;
            win_start = 1'b1;
            if (cv_done) begin
               state_nxt = last_k ? FIN : NEXT;
            end
         end
         NEXT: begin
            busy       = 1'b1;
            state_nxt  = LOAD;
            load_start = 1'b1;
         end
         FIN: begin
            busy       = 1'b1;
            layer_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      cv_state = busy & sel_q;
   end

   // Layer configuration is captured only when a go is accepted; the kernel counter steps in NEXT.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel_q   <= L1;
         nk_q    <= '0;
         wbase_q <= '0;
         k_cnt   <= '0;
      end else if (state == IDLE && go) begin
         sel_q   <= layer_sel;
         nk_q    <= nk_eff;
         wbase_q <= wbase;
         k_cnt   <= '0;
      end else if (state == NEXT) begin
         k_cnt <= k_cnt + 1'b1;
      end else if (state == FIN) begin
         k_cnt <= '0;
      end
   end

   // Gap timer counts idle cycles between the end of the weight load and the engine start.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gap_cnt <= '0;
      end else if (state == GAP) begin
         gap_cnt <= gap_cnt + 1'b1;
      end else begin
         gap_cnt <= '0;
      end
   end

endmodule
